// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port RAM (comb read, sync write).
// Optional per-burst XOR checksum outputs when RAM_BURST_CHECKSUM_EN is defined.
module ram_burst_ctrl #(
  parameter int address_width = 4,
  parameter int data_width    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [address_width-1:0] cmd_base,
  input  logic [address_width-1:0] cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [data_width-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [data_width-1:0]    rd_data,
  output logic                     rd_last,
  output logic                     busy,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data_in,
  output logic                     ram_write_enable,
  input  logic [data_width-1:0]    ram_data_out
`ifdef RAM_BURST_CHECKSUM_EN
  ,
  output logic [data_width-1:0]    csum,
  output logic                     csum_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic [address_width-1:0] addr;
    logic [address_width-1:0] remaining;
  } burst_t;

  state_t state, state_nxt;
  burst_t burst, burst_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
    end
  end

  // A handshaken beat advances the address (wrapping) and retires the burst on remaining==0.
  always_comb begin
    state_nxt        = state;
    burst_nxt        = burst;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    rd_valid         = 1'b0;
    rd_last          = 1'b0;
    rd_data          = '0;
    ram_address      = '0;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          burst_nxt.addr      = cmd_base;
          burst_nxt.remaining = cmd_len;
          state_nxt           = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready         = 1'b1;
        ram_address      = burst.addr;
        ram_data_in      = wr_data;
        ram_write_enable = wr_valid;
        if (wr_valid) begin
          burst_nxt.addr      = burst.addr + 1'b1;
          burst_nxt.remaining = burst.remaining - 1'b1;
          if (burst.remaining == '0) state_nxt = IDLE;
        end
      end
      READ: begin
        rd_valid    = 1'b1;
        ram_address = burst.addr;
        rd_data     = ram_data_out;
        rd_last     = (burst.remaining == '0);
        if (rd_ready) begin
          burst_nxt.addr      = burst.addr + 1'b1;
          burst_nxt.remaining = burst.remaining - 1'b1;
          if (burst.remaining == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef RAM_BURST_CHECKSUM_EN
  logic                  accept, beat, last_beat;
  logic [data_width-1:0] beat_data;

  assign accept    = (state == IDLE) && cmd_valid;
  assign beat      = ((state == WRITE) && wr_valid) || ((state == READ) && rd_ready);
  assign beat_data = (state == WRITE) ? wr_data : ram_data_out;
  assign last_beat = beat && (burst.remaining == '0);

  // csum_valid lands the cycle after the final beat, when csum already includes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= last_beat;
      if (accept)    csum <= '0;
      else if (beat) csum <= csum ^ beat_data;
    end
  end
`endif

endmodule
